// File: rtl/comparador_pkg.sv
// Shared types and elaboration helpers for the serial magnitude comparator.
package comparador_pkg;

  localparam logic [1:0] IDLE_ENC   = 2'd0;
  localparam logic [1:0] RUN_ENC    = 2'd1;
  localparam logic [1:0] FINISH_ENC = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = IDLE_ENC,
    RUN    = RUN_ENC,
    FINISH = FINISH_ENC
  } state_t;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << w) < n) w = w + 1;
    end
    return w;
  endfunction

  function automatic int steps_of(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/comparador_digito.sv
// Combinational DIGIT-bit slice compare: bitwise XNOR equality plus an
// MSB-first priority chain that picks gt/lt from the first differing bit.
module comparador_digito #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  logic [DIGIT-1:0] bit_eq;
  logic             found;

  assign bit_eq = ~(x ^ y);
  assign eq     = &bit_eq;

  always_comb begin
    gt    = 1'b0;
    lt    = 1'b0;
    found = 1'b0;
    for (int i = DIGIT - 1; i >= 0; i--) begin
      if (!found && !bit_eq[i]) begin
        found = 1'b1;
        gt    = x[i];
        lt    = y[i];
      end
    end
  end

endmodule

// File: rtl/comparador_magnitude_serial.sv
// Sequential MSB-first magnitude comparator, DIGIT bits per clock, with
// start/done handshake. Define COMPARADOR_EARLY_EXIT_EN to finish on the
// first differing slice instead of always walking all STEPS slices.
//
// state  | meaning
// IDLE   | waiting for start; flags hold the last result
// RUN    | comparing one slice per cycle, MSB slice first
// FINISH | done pulse, flags valid; start accepted here too
module comparador_magnitude_serial
  import comparador_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             aeqb,
  output logic             agtb,
  output logic             altb
);

  localparam int STEPS = steps_of(WIDTH, DIGIT);
  localparam int CW    = cnt_width(STEPS);
  localparam logic [CW-1:0]    LAST     = CW'(STEPS - 1);
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef COMPARADOR_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  state_t           state, state_nx;
  logic [WIDTH-1:0] opa, opb, opa_nx, opb_nx;
  logic [CW-1:0]    step, step_nx;
  logic             decided, gt, lt;
  logic             decided_nx, gt_nx, lt_nx;
  logic             busy_nx, done_nx, aeqb_nx, agtb_nx, altb_nx;
  logic             s_eq, s_gt, s_lt;
  logic             leave;

  comparador_digito #(.DIGIT(DIGIT)) u_digito (
    .x  (opa[WIDTH-1 -: DIGIT]),
    .y  (opb[WIDTH-1 -: DIGIT]),
    .eq (s_eq),
    .gt (s_gt),
    .lt (s_lt)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    opa_nx     = opa;
    opb_nx     = opb;
    step_nx    = step;
    decided_nx = decided;
    gt_nx      = gt;
    lt_nx      = lt;
    busy_nx    = busy;
    done_nx    = 1'b0;
    aeqb_nx    = aeqb;
    agtb_nx    = agtb;
    altb_nx    = altb;
    leave      = 1'b0;

    unique case (state)
      IDLE, FINISH: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
        if (start) begin
          // Offset binary: flipping both MSBs makes signed order match unsigned.
          opa_nx     = signed_mode ? (a ^ MSB_MASK) : a;
          opb_nx     = signed_mode ? (b ^ MSB_MASK) : b;
          step_nx    = '0;
          decided_nx = 1'b0;
          gt_nx      = 1'b0;
          lt_nx      = 1'b0;
          aeqb_nx    = 1'b0;
          agtb_nx    = 1'b0;
          altb_nx    = 1'b0;
          busy_nx    = 1'b1;
          state_nx   = RUN;
        end
      end
      RUN: begin
        opa_nx  = opa << DIGIT;
        opb_nx  = opb << DIGIT;
        step_nx = step + CW'(1);
        if (!decided && !s_eq) begin
          decided_nx = 1'b1;
          gt_nx      = s_gt;
          lt_nx      = s_lt;
          leave      = EARLY_EXIT;
        end
        if (step == LAST) leave = 1'b1;
        if (leave) begin
          state_nx = FINISH;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
          agtb_nx  = gt_nx;
          altb_nx  = lt_nx;
          aeqb_nx  = ~decided_nx;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      opa     <= '0;
      opb     <= '0;
      step    <= '0;
      decided <= 1'b0;
      gt      <= 1'b0;
      lt      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      aeqb    <= 1'b0;
      agtb    <= 1'b0;
      altb    <= 1'b0;
    end else begin
      opa     <= opa_nx;
      opb     <= opb_nx;
      step    <= step_nx;
      decided <= decided_nx;
      gt      <= gt_nx;
      lt      <= lt_nx;
      busy    <= busy_nx;
      done    <= done_nx;
      aeqb    <= aeqb_nx;
      agtb    <= agtb_nx;
      altb    <= altb_nx;
    end
  end

endmodule

// File: tb/tb_comparador_magnitude_serial.sv
// Randomised self-checking bench for comparador_magnitude_serial, WIDTH=8 DIGIT=2.
module tb_comparador_magnitude_serial;

  localparam int WIDTH = 8;
  localparam int DIGIT = 2;
  localparam int STEPS = WIDTH / DIGIT;

  logic             clk = 1'b0;
  logic             reset, start, signed_mode;
  logic [WIDTH-1:0] a, b;
  logic             busy, done, aeqb, agtb, altb;

  int checks = 0;
  int errors = 0;

  comparador_magnitude_serial #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy), .done(done),
    .aeqb(aeqb), .agtb(agtb), .altb(altb)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected {aeqb, agtb, altb} from plain integer ordering.
  function automatic logic [2:0] ref_flags(input logic [7:0] x, input logic [7:0] y, input bit sm);
    int xi, yi;
    if (sm) begin
      xi = int'($signed(x));
      yi = int'($signed(y));
    end else begin
      xi = int'(x);
      yi = int'(y);
    end
    if (xi == yi) return 3'b100;
    if (xi > yi)  return 3'b010;
    return 3'b001;
  endfunction

  // Cycle (counted from the accept cycle = 0) in which done is expected.
  function automatic int ref_lat(input logic [7:0] x, input logic [7:0] y);
`ifdef COMPARADOR_EARLY_EXIT_EN
    int sx, sy;
    for (int j = 1; j <= STEPS; j++) begin
      sx = (int'(x) >> (WIDTH - DIGIT * j)) % (1 << DIGIT);
      sy = (int'(y) >> (WIDTH - DIGIT * j)) % (1 << DIGIT);
      if (sx != sy) return j + 1;
    end
`endif
    return STEPS + 1;
  endfunction

  // Called in cycle 1 of a comparison; returns in the done cycle.
  task automatic wait_check(input logic [7:0] ta, input logic [7:0] tb, input bit sm,
                            input int pulse, input string name);
    int lat;
    logic [2:0] want;
    int wl;
    want = ref_flags(ta, tb, sm);
    wl   = ref_lat(ta, tb);
    lat  = 1;
    while (done !== 1'b1 && lat <= 20) begin
      checks++;
      if (busy !== 1'b1 || {aeqb, agtb, altb} !== 3'b000)
        $display("FAIL %s busy-phase: busy=%b flags=%b want busy=1 flags=000 (cycle %0d)",
                 name, busy, {aeqb, agtb, altb}, lat);
      if (lat == pulse) begin
        start = 1'b1; a = 8'h00; b = 8'hFF; signed_mode = 1'($urandom);
      end else begin
        start = 1'b0; a = 8'($urandom); b = 8'($urandom); signed_mode = 1'($urandom);
      end
      tick();
      lat++;
    end
    start = 1'b0;
    checks++;
    if (lat != wl) begin
      errors++;
      $display("FAIL %s latency: done in cycle %0d want %0d", name, lat, wl);
    end
    checks++;
    if ({aeqb, agtb, altb} !== want) begin
      errors++;
      $display("FAIL %s flags: got %b want %b (a=%h b=%h signed=%0d)",
               name, {aeqb, agtb, altb}, want, ta, tb, sm);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy-at-done: got %b want 0", name, busy);
    end
  endtask

  task automatic do_cmp(input logic [7:0] ta, input logic [7:0] tb, input bit sm, input string name);
    logic [2:0] want;
    want = ref_flags(ta, tb, sm);
    start = 1'b1; a = ta; b = tb; signed_mode = sm;
    tick();
    wait_check(ta, tb, sm, 0, name);
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || {aeqb, agtb, altb} !== want) begin
      errors++;
      $display("FAIL %s hold: done=%b busy=%b flags=%b want 0 0 %b",
               name, done, busy, {aeqb, agtb, altb}, want);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    tick(); tick();
    checks++;
    if ({busy, done, aeqb, agtb, altb} !== 5'b0) begin
      errors++;
      $display("FAIL reset_state: got %b want 00000", {busy, done, aeqb, agtb, altb});
    end
    start = 1'b1; a = 8'h12; b = 8'h34;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_wins: busy=%b want 0", busy);
    end
    reset = 1'b0; start = 1'b0;
    tick();
  endtask

  task automatic test_plan();
    do_cmp(8'hA5, 8'hA5, 1'b0, "eq_a5");
    do_cmp(8'h80, 8'h7F, 1'b0, "u_80_7f");
    do_cmp(8'h80, 8'h7F, 1'b1, "s_80_7f");
    do_cmp(8'hFF, 8'h00, 1'b1, "s_ff_00");
    do_cmp(8'h01, 8'hFF, 1'b1, "s_01_ff");
    do_cmp(8'h40, 8'h00, 1'b0, "u_40_00");
    do_cmp(8'h00, 8'h01, 1'b0, "u_lsb");
  endtask

  task automatic test_random();
    logic [7:0] ra, rb;
    bit rs;
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      if (i % 5 == 0) rb = ra;
      do_cmp(ra, rb, rs, "random");
    end
  endtask

  task automatic test_back_to_back();
    start = 1'b1; a = 8'hA5; b = 8'hA5; signed_mode = 1'b0;
    tick();
    wait_check(8'hA5, 8'hA5, 1'b0, 2, "busy_start_ignored");
    start = 1'b1; a = 8'h12; b = 8'h34; signed_mode = 1'b0;
    tick();
    wait_check(8'h12, 8'h34, 1'b0, 0, "start_on_done");
    start = 1'b1; a = 8'hC0; b = 8'h3F; signed_mode = 1'b1;
    tick();
    wait_check(8'hC0, 8'h3F, 1'b1, 0, "start_on_done_signed");
    tick();
  endtask

  task automatic test_reset_mid();
    bit seen;
    start = 1'b1; a = 8'hA5; b = 8'hA5; signed_mode = 1'b0;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({busy, done, aeqb, agtb, altb} !== 5'b0) begin
      errors++;
      $display("FAIL reset_mid_run: got %b want 00000", {busy, done, aeqb, agtb, altb});
    end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done === 1'b1) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_mid_no_done: done seen=1 want 0");
    end
  endtask

  initial begin
    test_reset();
    test_plan();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
